car_animator: RTL and testbench

- Sequencer directly upstream of the car sprite drawer. It owns the car's screen position and heading.
- Once per frame tick it erases the old car footprint by plotting a 15x15 background box, steps the position one pixel in the requested direction with screen-edge clamping, then requests a redraw from the drawer and waits for its done.
- It also muxes its own erase pixels and the drawer's pixels onto the single VGA pixel port.

---
 rtl/car_animator_if.sv | 37 +++
 rtl/car_animator.sv | 198 +++++++++++++++++++
 tb/tb_car_animator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/car_animator_if.sv
`default_nettype none
// ============================================================================
// Module      : car_animator_if
// Description : Frame-control, drawer handshake and VGA pixel bundle for the
//               car animator.
// Revision    : 1.0 - initial release
// ============================================================================
interface car_animator_if;
    logic       iEnable;
    logic [2:0] iDir;
    logic       iMove;
    logic [7:0] oCarX;
    logic [6:0] oCarY;
    logic [2:0] oDir;
    logic       oDrawCar;
    logic       iCarDone;
    logic [7:0] iCarX;
    logic [6:0] iCarY;
    logic [8:0] iCarColour;
    logic       iCarPlot;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [8:0] oColour;
    logic       oPlot;
    logic       oFrameDone;

    modport slave (
        input  iEnable, iDir, iMove, iCarDone, iCarX, iCarY, iCarColour, iCarPlot,
        output oCarX, oCarY, oDir, oDrawCar, oX, oY, oColour, oPlot, oFrameDone
    );

    modport master (
        output iEnable, iDir, iMove, iCarDone, iCarX, iCarY, iCarColour, iCarPlot,
        input  oCarX, oCarY, oDir, oDrawCar, oX, oY, oColour, oPlot, oFrameDone
    );
endinterface
`default_nettype wire

// File: rtl/car_animator.sv
`default_nettype none
// ============================================================================
// Module      : car_animator
// Description : Per-frame erase / move / redraw sequencer for the car sprite,
//               muxing its erase pixels and the drawer's pixels onto VGA.
// Revision    : 1.0 - initial release
// ============================================================================
module car_animator #(
    parameter int         X_SCREEN_PIXELS = 160,
    parameter int         Y_SCREEN_PIXELS = 120,
    parameter int         BOX             = 15,
    parameter int         FRAME_DIV       = 833334,
    parameter int         X_START         = 76,
    parameter int         Y_START         = 52,
    parameter logic [8:0] BG_COLOUR       = 9'h000
) (
    input  wire logic     iClock,
    input  wire logic     iResetn,
    car_animator_if.slave bus
);

    localparam int c_DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int c_BOX_W = $clog2(BOX);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);
    localparam logic [c_BOX_W-1:0] c_BOX_LAST = c_BOX_W'(BOX - 1);
    localparam logic signed [8:0]  c_X_MAX    = 9'(X_SCREEN_PIXELS - BOX);
    localparam logic signed [8:0]  c_Y_MAX    = 9'(Y_SCREEN_PIXELS - BOX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ERASE     = 3'd1,
        S_UPDATE    = 3'd2,
        S_DRAW_REQ  = 3'd3,
        S_DRAW_WAIT = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div;
    logic                w_tick;
    logic                r_pending;
    logic [c_BOX_W-1:0]  r_cx;
    logic [c_BOX_W-1:0]  r_cy;
    logic [7:0]          r_ex;
    logic [6:0]          r_ey;
    logic [7:0]          r_car_x;
    logic [6:0]          r_car_y;
    logic [2:0]          r_dir;
    logic [7:0]          r_hold_x;
    logic [6:0]          r_hold_y;
    logic [8:0]          r_hold_c;
    logic signed [8:0]   w_dx;
    logic signed [8:0]   w_dy;
    logic signed [8:0]   w_nx;
    logic signed [8:0]   w_ny;
    logic [7:0]          w_new_x;
    logic [6:0]          w_new_y;
    logic                w_erase_last;

    assign w_tick       = bus.iEnable && (r_div == c_DIV_LAST);
    assign w_erase_last = (r_cx == c_BOX_LAST) && (r_cy == c_BOX_LAST);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_tick || r_pending) w_state_nxt = S_ERASE;
            S_ERASE:     if (w_erase_last) w_state_nxt = S_UPDATE;
            S_UPDATE:    w_state_nxt = S_DRAW_REQ;
            S_DRAW_REQ:  w_state_nxt = S_DRAW_WAIT;
            S_DRAW_WAIT: if (bus.iCarDone) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // One-pixel step in signed 9-bit space so a step off either edge clamps cleanly.
    always_comb begin
        w_dx = 9'sd0;
        w_dy = 9'sd0;
        case (bus.iDir)
            3'd7, 3'd0, 3'd1: w_dx = 9'sd1;
            3'd3, 3'd4, 3'd5: w_dx = -9'sd1;
            default:          w_dx = 9'sd0;
        endcase
        case (bus.iDir)
            3'd1, 3'd2, 3'd3: w_dy = -9'sd1;
            3'd5, 3'd6, 3'd7: w_dy = 9'sd1;
            default:          w_dy = 9'sd0;
        endcase
        w_nx = $signed({1'b0, r_car_x}) + w_dx;
        w_ny = $signed({2'b00, r_car_y}) + w_dy;
        if (w_nx < 9'sd0)        w_new_x = 8'd0;
        else if (w_nx > c_X_MAX) w_new_x = c_X_MAX[7:0];
        else                     w_new_x = w_nx[7:0];
        if (w_ny < 9'sd0)        w_new_y = 7'd0;
        else if (w_ny > c_Y_MAX) w_new_y = c_Y_MAX[6:0];
        else                     w_new_y = w_ny[6:0];
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_div     <= '0;
            r_pending <= 1'b0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_ex      <= 8'd0;
            r_ey      <= 7'd0;
            r_car_x   <= 8'(X_START);
            r_car_y   <= 7'(Y_START);
            r_dir     <= 3'd0;
            r_hold_x  <= 8'd0;
            r_hold_y  <= 7'd0;
            r_hold_c  <= 9'd0;
        end else begin
            if (!bus.iEnable || (r_div == c_DIV_LAST)) r_div <= '0;
            else                                       r_div <= r_div + c_DIV_W'(1);

            // IDLE always consumes the pending flag; a tick arriving alongside it is dropped.
            if (r_state == S_IDLE) r_pending <= 1'b0;
            else if (w_tick)       r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_cx <= '0;
                    r_cy <= '0;
                    r_ex <= r_car_x;
                    r_ey <= r_car_y;
                end
                S_ERASE: begin
                    r_hold_x <= r_ex;
                    r_hold_y <= r_ey;
                    r_hold_c <= BG_COLOUR;
                    if (r_cx == c_BOX_LAST) begin
                        r_cx <= '0;
                        r_ex <= r_car_x;
                        r_cy <= r_cy + c_BOX_W'(1);
                        r_ey <= r_ey + 7'd1;
                    end else begin
                        r_cx <= r_cx + c_BOX_W'(1);
                        r_ex <= r_ex + 8'd1;
                    end
                end
                S_UPDATE: begin
                    r_dir <= bus.iDir;
                    if (bus.iMove) begin
                        r_car_x <= w_new_x;
                        r_car_y <= w_new_y;
                    end
                end
                S_DRAW_WAIT: begin
                    r_hold_x <= bus.iCarX;
                    r_hold_y <= bus.iCarY;
                    r_hold_c <= bus.iCarColour;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.oX      = r_hold_x;
        bus.oY      = r_hold_y;
        bus.oColour = r_hold_c;
        bus.oPlot   = 1'b0;
        case (r_state)
            S_ERASE: begin
                bus.oX      = r_ex;
                bus.oY      = r_ey;
                bus.oColour = BG_COLOUR;
                bus.oPlot   = 1'b1;
            end
            S_DRAW_WAIT: begin
                bus.oX      = bus.iCarX;
                bus.oY      = bus.iCarY;
                bus.oColour = bus.iCarColour;
                bus.oPlot   = bus.iCarPlot;
            end
            default: ;
        endcase
    end

    assign bus.oCarX      = r_car_x;
    assign bus.oCarY      = r_car_y;
    assign bus.oDir       = r_dir;
    assign bus.oDrawCar   = (r_state == S_DRAW_REQ);
    assign bus.oFrameDone = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_car_animator.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_animator
// Description : Directed scoreboard bench for car_animator with a drawer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_animator;

    logic iClock  = 1'b0;
    logic iResetn = 1'b0;

    car_animator_if bus ();

    car_animator #(.FRAME_DIV(8)) dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .bus     (bus.slave)
    );

    always #5 iClock = ~iClock;

    int          total  = 0;
    int          bad    = 0;
    int          frames = 0;
    int          draws  = 0;
    int          mx     = 76;
    int          my     = 52;
    logic [23:0] exp_q[$];
    logic [23:0] e_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Every plotted pixel is popped from the scoreboard in order.
    always @(negedge iClock) begin
        if (iResetn === 1'b1) begin
            if (bus.oDrawCar === 1'b1) draws++;
            if (bus.oPlot === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("plot_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e_pix = exp_q.pop_front();
                    check("pixel", {8'd0, bus.oX, bus.oY, bus.oColour}, {8'd0, e_pix});
                end
            end
        end
    end

    task automatic push_erase();
        for (int cy = 0; cy < 15; cy++)
            for (int cx = 0; cx < 15; cx++)
                exp_q.push_back({8'(mx + cx), 7'(my + cy), 9'h000});
    endtask

    task automatic step_model(input logic [2:0] d, input logic mv);
        int dx;
        int dy;
        dx = 0;
        dy = 0;
        if (mv) begin
            if (d == 3'd0 || d == 3'd1 || d == 3'd7) dx = 1;
            if (d == 3'd3 || d == 3'd4 || d == 3'd5) dx = -1;
            if (d == 3'd1 || d == 3'd2 || d == 3'd3) dy = -1;
            if (d == 3'd5 || d == 3'd6 || d == 3'd7) dy = 1;
        end
        mx = mx + dx;
        my = my + dy;
        if (mx < 0)   mx = 0;
        if (mx > 145) mx = 145;
        if (my < 0)   my = 0;
        if (my > 105) my = 105;
    endtask

    // Enable the divider until the first erase plot appears, then hold it off.
    task automatic start_tick();
        int n;
        n = 0;
        bus.iEnable = 1'b1;
        while (bus.oPlot !== 1'b1 && n < 40) begin
            @(posedge iClock); #1;
            n++;
        end
        bus.iEnable = 1'b0;
        check("tick_latency", 32'(n), 32'd8);
        if (n >= 40) finish_run();
    endtask

    // Called on the first erase cycle; returns on the DONE cycle.
    // mode 1: iCarDone pulsed during erase; 2: drawer pixel pass-through; 3: two ticks while busy.
    task automatic finish_frame(input logic [2:0] d, input logic mv, input int dly, input int mode);
        int n;
        n = 0;
        if (mode == 1) bus.iCarDone = 1'b1;
        if (mode == 3) bus.iEnable  = 1'b1;
        while (bus.oDrawCar !== 1'b1 && n < 400) begin
            @(posedge iClock); #1;
            n++;
            bus.iCarDone = 1'b0;
            if (mode == 3 && n == 16) bus.iEnable = 1'b0;
        end
        check("draw_latency", 32'(n), 32'd226);
        if (n >= 400) finish_run();
        step_model(d, mv);
        frames++;
        check("car_x", 32'(bus.oCarX), 32'(mx));
        check("car_y", 32'(bus.oCarY), 32'(my));
        check("car_dir", 32'(bus.oDir), 32'(d));
        for (int i = 0; i < dly; i++) begin
            @(posedge iClock); #1;
            bus.iCarPlot = 1'b0;
            if (mode == 2 && i == 0) begin
                bus.iCarX      = 8'd100;
                bus.iCarY      = 7'd20;
                bus.iCarColour = 9'h1C0;
                bus.iCarPlot   = 1'b1;
                exp_q.push_back({8'd100, 7'd20, 9'h1C0});
                #1;
                check("pass_x", 32'(bus.oX), 32'd100);
                check("pass_y", 32'(bus.oY), 32'd20);
                check("pass_colour", 32'(bus.oColour), 32'h1C0);
                check("pass_plot", 32'(bus.oPlot), 32'd1);
            end
        end
        bus.iCarPlot = 1'b0;
        bus.iCarDone = 1'b1;
        @(posedge iClock); #1;
        bus.iCarDone = 1'b0;
        check("frame_done", 32'(bus.oFrameDone), 32'd1);
    endtask

    task automatic idle_check();
        @(posedge iClock); #1;
        check("done_cleared", 32'(bus.oFrameDone), 32'd0);
        check("idle_plot", 32'(bus.oPlot), 32'd0);
    endtask

    task automatic frame(input logic [2:0] d, input logic mv);
        bus.iDir  = d;
        bus.iMove = mv;
        push_erase();
        start_tick();
        finish_frame(d, mv, 2, 0);
        idle_check();
    endtask

    initial begin
        bus.iEnable    = 1'b0;
        bus.iDir       = 3'd0;
        bus.iMove      = 1'b0;
        bus.iCarDone   = 1'b0;
        bus.iCarX      = 8'd0;
        bus.iCarY      = 7'd0;
        bus.iCarColour = 9'd0;
        bus.iCarPlot   = 1'b0;
        repeat (3) @(posedge iClock);
        #1;
        check("rst_car_x", 32'(bus.oCarX), 32'd76);
        check("rst_car_y", 32'(bus.oCarY), 32'd52);
        check("rst_dir", 32'(bus.oDir), 32'd0);
        check("rst_draw", 32'(bus.oDrawCar), 32'd0);
        check("rst_frame_done", 32'(bus.oFrameDone), 32'd0);
        check("rst_pixel", {8'd0, bus.oX, bus.oY, bus.oColour}, 32'd0);
        check("rst_plot", 32'(bus.oPlot), 32'd0);
        iResetn = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        check("no_tick_when_disabled", 32'(bus.oPlot), 32'd0);

        // Stationary frame with a 10-cycle drawer
        bus.iDir  = 3'd0;
        bus.iMove = 1'b0;
        push_erase();
        start_tick();
        finish_frame(3'd0, 1'b0, 10, 0);
        idle_check();

        // Three steps east
        for (int k = 0; k < 3; k++) frame(3'd0, 1'b1);
        check("east_x", 32'(bus.oCarX), 32'd79);
        check("east_y", 32'(bus.oCarY), 32'd52);

        // Stray done during erase, then drawer pixel pass-through
        bus.iDir  = 3'd2;
        bus.iMove = 1'b1;
        push_erase();
        start_tick();
        finish_frame(3'd2, 1'b1, 4, 1);
        idle_check();
        bus.iDir  = 3'd0;
        bus.iMove = 1'b0;
        push_erase();
        start_tick();
        finish_frame(3'd0, 1'b0, 4, 2);
        idle_check();
        check("hold_x", 32'(bus.oX), 32'd100);

        // Top-right corner clamp
        while (my > 0)   frame(3'd1, 1'b1);
        while (mx < 145) frame(3'd0, 1'b1);
        frame(3'd1, 1'b1);
        check("clamp_x", 32'(bus.oCarX), 32'd145);
        check("clamp_y", 32'(bus.oCarY), 32'd0);

        // Two ticks during a busy frame: one pending frame, the other dropped
        bus.iDir  = 3'd6;
        bus.iMove = 1'b1;
        push_erase();
        start_tick();
        finish_frame(3'd6, 1'b1, 30, 3);
        push_erase();
        @(posedge iClock); #1;
        check("pending_idle", 32'(bus.oPlot), 32'd0);
        @(posedge iClock); #1;
        check("pending_start", 32'(bus.oPlot), 32'd1);
        finish_frame(3'd6, 1'b1, 2, 0);
        idle_check();
        repeat (40) @(posedge iClock);
        #1;
        check("no_third_frame", 32'(draws), 32'(frames));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset at erase pixel 100
        bus.iDir  = 3'd4;
        bus.iMove = 1'b1;
        push_erase();
        start_tick();
        repeat (100) @(posedge iClock);
        #1;
        iResetn = 1'b0;
        #1;
        check("abort_plot", 32'(bus.oPlot), 32'd0);
        check("abort_car_x", 32'(bus.oCarX), 32'd76);
        check("abort_car_y", 32'(bus.oCarY), 32'd52);
        check("abort_pixels_left", 32'(exp_q.size()), 32'd125);
        exp_q.delete();
        mx = 76;
        my = 52;
        @(posedge iClock); #1;
        iResetn = 1'b1;
        repeat (5) @(posedge iClock);
        #1;
        check("after_reset_idle", 32'(bus.oPlot), 32'd0);

        // Left-edge clamp heading west then south-west
        while (mx > 0) frame(3'd4, 1'b1);
        frame(3'd5, 1'b1);
        check("left_clamp_x", 32'(bus.oCarX), 32'd0);
        check("left_clamp_y", 32'(bus.oCarY), 32'd53);

        check("draw_count", 32'(draws), 32'(frames));
        check("final_queue", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

endmodule
`default_nettype wire
